// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM encoding, coin values,
// datapath widths and the timer-width helper.
package change_pkg;

  localparam int AMT_W = 8;
  localparam int INV_W = 8;

  localparam logic [AMT_W-1:0] VAL_Q = 8'd25;
  localparam logic [AMT_W-1:0] VAL_D = 8'd10;
  localparam logic [AMT_W-1:0] VAL_N = 8'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_e;

  function automatic logic [AMT_W-1:0] coin_value(input coin_e c);
    case (c)
      COIN_Q:  return VAL_Q;
      COIN_D:  return VAL_D;
      COIN_N:  return VAL_N;
      default: return '0;
    endcase
  endfunction

  // Smallest counter width able to hold the larger of the two durations.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases; `last` flags the
// final cycle of the loaded duration.
module dispense_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser (quarter/dime/nickel) with timed eject pulses.
// Define CHANGE_INV_EN to add per-denomination inventory tracking and load ports.
module change_dispenser
  import change_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
`ifdef CHANGE_INV_EN
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv_q,
  input  logic [INV_W-1:0] inv_d,
  input  logic [INV_W-1:0] inv_n,
`endif
  output logic             quarter_out,
  output logic             dime_out,
  output logic             nickel_out,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remain
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d, take;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic             fault_q, fault_d;
  logic             tmr_load, tmr_last;
  logic [CNT_W-1:0] tmr_val;
  logic             avail_qtr, avail_dime, avail_nkl;

`ifdef CHANGE_INV_EN
  logic [INV_W-1:0] qtr_cnt_q, dime_cnt_q, nkl_cnt_q;
  logic [INV_W-1:0] qtr_cnt_d, dime_cnt_d, nkl_cnt_d;

  // A load landing with start is taken on the same edge, so SELECT sees new counts.
  always_comb begin
    qtr_cnt_d  = qtr_cnt_q;
    dime_cnt_d = dime_cnt_q;
    nkl_cnt_d  = nkl_cnt_q;
    if (state_q == S_IDLE && inv_load) begin
      qtr_cnt_d  = inv_q;
      dime_cnt_d = inv_d;
      nkl_cnt_d  = inv_n;
    end else begin
      case (take)
        COIN_Q:  qtr_cnt_d  = qtr_cnt_q - 1'b1;
        COIN_D:  dime_cnt_d = dime_cnt_q - 1'b1;
        COIN_N:  nkl_cnt_d  = nkl_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      qtr_cnt_q  <= '0;
      dime_cnt_q <= '0;
      nkl_cnt_q  <= '0;
    end else begin
      qtr_cnt_q  <= qtr_cnt_d;
      dime_cnt_q <= dime_cnt_d;
      nkl_cnt_q  <= nkl_cnt_d;
    end
  end

  assign avail_qtr  = (qtr_cnt_q  != '0);
  assign avail_dime = (dime_cnt_q != '0);
  assign avail_nkl  = (nkl_cnt_q  != '0);
`else
  assign avail_qtr  = 1'b1;
  assign avail_dime = 1'b1;
  assign avail_nkl  = 1'b1;
`endif

  dispense_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      coin_q   <= COIN_NONE;
      remain_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      coin_q   <= coin_d;
      remain_q <= remain_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    remain_d = remain_q;
    fault_d  = fault_q;
    take     = COIN_NONE;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = amount;
          fault_d  = 1'b0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        // Greedy: largest payable coin first, never revisiting an earlier choice.
        if (remain_q == '0) begin
          state_d = S_DONE;
        end else if (remain_q >= VAL_Q && avail_qtr) begin
          take = COIN_Q;
        end else if (remain_q >= VAL_D && avail_dime) begin
          take = COIN_D;
        end else if (remain_q >= VAL_N && avail_nkl) begin
          take = COIN_N;
        end else begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
        if (take != COIN_NONE) begin
          state_d  = S_PULSE;
          coin_d   = take;
          remain_d = remain_q - coin_value(take);
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYCLES);
        end
      end
      S_PULSE: begin
        if (tmr_last) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_CYCLES);
        end
      end
      S_GAP: begin
        if (tmr_last) state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign quarter_out = (state_q == S_PULSE) && (coin_q == COIN_Q);
  assign dime_out    = (state_q == S_PULSE) && (coin_q == COIN_D);
  assign nickel_out  = (state_q == S_PULSE) && (coin_q == COIN_N);
  assign busy        = (state_q == S_SELECT) || (state_q == S_PULSE) || (state_q == S_GAP);
  assign done        = (state_q == S_DONE);
  assign fault       = fault_q;
  assign remain      = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coin sequences are queued at
// start and checked by a negedge monitor as the pulses appear.
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int PER_COIN = 1 + PULSE + GAP;

  localparam logic [2:0] CQ = 3'b100;
  localparam logic [2:0] CD = 3'b010;
  localparam logic [2:0] CN = 3'b001;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
`ifdef CHANGE_INV_EN
  logic       inv_load = 1'b0;
  logic [7:0] inv_q = 8'd0;
  logic [7:0] inv_d = 8'd0;
  logic [7:0] inv_n = 8'd0;
`endif
  logic       quarter_out, dime_out, nickel_out, busy, done, fault;
  logic [7:0] remain;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  change_dispenser #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .amount      (amount),
`ifdef CHANGE_INV_EN
    .inv_load    (inv_load),
    .inv_q       (inv_q),
    .inv_d       (inv_d),
    .inv_n       (inv_n),
`endif
    .quarter_out (quarter_out),
    .dime_out    (dime_out),
    .nickel_out  (nickel_out),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .remain      (remain)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coin monitor: type, pulse width and inter-pulse low time (gap plus the SELECT cycle).
  logic [2:0] mon_c, mon_prev;
  int         hi_len, lo_len;
  bit         have_prev;

  always @(negedge clk) begin
    mon_c = {quarter_out, dime_out, nickel_out};
    if (!nrst) begin
      mon_prev  = 3'b000;
      hi_len    = 0;
      lo_len    = 0;
      have_prev = 1'b0;
    end else begin
      if (mon_c != 3'b000) chk("onehot", 32'($onehot(mon_c)), 32'd1);
      if (mon_c != 3'b000 && mon_prev == 3'b000) begin
        if (have_prev) chk("gap_len", lo_len, GAP + 1);
        if (exp_q.size() == 0) chk("unexpected_coin", 32'(mon_c), 32'd0);
        else chk("coin_type", 32'(mon_c), 32'(exp_q.pop_front()));
        hi_len = 1;
      end else if (mon_c != 3'b000) begin
        hi_len++;
      end else if (mon_prev != 3'b000) begin
        chk("pulse_len", hi_len, PULSE);
        lo_len    = 1;
        have_prev = 1'b1;
      end else begin
        lo_len++;
      end
      if (!busy) have_prev = 1'b0;
      mon_prev = mon_c;
    end
  end

  task automatic do_start(input logic [7:0] a);
    @(posedge clk); #1;
    amount = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_end(input int maxc, output bit got_done, output bit got_fault,
                          output int busy_cyc, output int n_cyc);
    got_done = 0; got_fault = 0; busy_cyc = 0; n_cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      n_cyc = i + 1;
      if (busy) busy_cyc++;
      if (done) got_done = 1;
      if (fault) got_fault = 1;
      if (done || fault) break;
    end
  endtask

  bit gd, gf;
  int bc, nc;
  bit seen_low, seen_q2;

  initial begin
    #1;
    chk("rst_quarter", quarter_out, 0);
    chk("rst_dime", dime_out, 0);
    chk("rst_nickel", nickel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_remain", remain, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

`ifdef CHANGE_INV_EN
    @(posedge clk); #1;
    inv_q = 8'd10; inv_d = 8'd10; inv_n = 8'd10; inv_load = 1'b1;
    @(posedge clk); #1;
    inv_load = 1'b0;
`endif

    // 65 cents: Q Q D N
    exp_q.push_back(CQ); exp_q.push_back(CQ); exp_q.push_back(CD); exp_q.push_back(CN);
    do_start(8'd65);
    wait_end(400, gd, gf, bc, nc);
    chk("a65_done", gd, 1);
    chk("a65_fault", gf, 0);
    chk("a65_remain", remain, 0);
    chk("a65_busy_cycles", bc, 4 * PER_COIN + 1);
    chk("a65_coins_left", exp_q.size(), 0);
    @(negedge clk);
    chk("a65_done_one_cycle", done, 0);

    // 0 cents: SELECT then DONE, no coins
    do_start(8'd0);
    wait_end(20, gd, gf, bc, nc);
    chk("a0_done", gd, 1);
    chk("a0_done_cycle", nc, 2);
    chk("a0_busy_cycles", bc, 1);

    // 37 cents: Q D then 2-cent residue faults
    exp_q.push_back(CQ); exp_q.push_back(CD);
    do_start(8'd37);
    wait_end(400, gd, gf, bc, nc);
    chk("a37_fault", gf, 1);
    chk("a37_no_done", gd, 0);
    chk("a37_remain", remain, 2);
    chk("a37_busy_cycles", bc, 2 * PER_COIN + 1);
    chk("a37_coins_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("a37_fault_held", fault, 1);
    chk("a37_remain_held", remain, 2);
    do_start(8'd0);
    @(negedge clk);
    chk("fault_cleared_by_start", fault, 0);
    wait_end(20, gd, gf, bc, nc);
    chk("a0b_done", gd, 1);

    // 50 cents, start re-pulsed mid-run, reset during second quarter
    exp_q.push_back(CQ); exp_q.push_back(CQ);
    do_start(8'd50);
    repeat (2) @(posedge clk); #1;
    amount = 8'd99;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(negedge clk);
    chk("restart_ignored_remain", remain, 25);
    chk("restart_ignored_quarter", quarter_out, 1);
    seen_low = 0; seen_q2 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!quarter_out) seen_low = 1;
      if (seen_low && quarter_out) begin seen_q2 = 1; break; end
    end
    chk("q2_seen", seen_q2, 1);
    @(posedge clk); #1;
    chk("q2_before_rst", quarter_out, 1);
    nrst = 1'b0;
    #1;
    chk("rst_mid_quarter", quarter_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_remain", remain, 0);
    chk("rst_mid_fault", fault, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_resume_busy", busy, 0);
    chk("no_resume_quarter", quarter_out, 0);

`ifdef CHANGE_INV_EN
    // Load 0/1/6 coincident with start of 40: one dime then six nickels
    exp_q.push_back(CD);
    for (int i = 0; i < 6; i++) exp_q.push_back(CN);
    @(posedge clk); #1;
    inv_q = 8'd0; inv_d = 8'd1; inv_n = 8'd6; inv_load = 1'b1;
    amount = 8'd40; start = 1'b1;
    @(posedge clk); #1;
    inv_load = 1'b0; start = 1'b0;
    wait_end(600, gd, gf, bc, nc);
    chk("a40_done", gd, 1);
    chk("a40_fault", gf, 0);
    chk("a40_coins_left", exp_q.size(), 0);
    do_start(8'd5);
    wait_end(20, gd, gf, bc, nc);
    chk("empty_inv_fault", gf, 1);
    chk("empty_inv_remain", remain, 5);
`else
    // 255 cents: ten quarters then one nickel
    for (int i = 0; i < 10; i++) exp_q.push_back(CQ);
    exp_q.push_back(CN);
    do_start(8'd255);
    wait_end(1000, gd, gf, bc, nc);
    chk("a255_done", gd, 1);
    chk("a255_fault", gf, 0);
    chk("a255_remain", remain, 0);
    chk("a255_busy_cycles", bc, 11 * PER_COIN + 1);
    chk("a255_coins_left", exp_q.size(), 0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
